// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- MBIST engine driving a memory with registered
// write data (sampled one cycle ahead of the write) and 2-cycle read latency.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, bg_mode      run request (honoured in IDLE/DONE), data background
//   write_read, address memory command (1 = write), word address
//   wdata, rdata        write data (leads its write by one cycle), read data
//   busy, done          run in progress, run finished (held until restart)
//   fail, fail_addr,    sticky mismatch flag, first failing address,
//   fail_elem, fail_cnt first failing March element, saturating mismatch count
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CAPACITY   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            bg_mode,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [7:0]            fail_cnt
);

  localparam int unsigned EW = 3;
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(CAPACITY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Data background P(a); only the address LSB matters.
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0] bg, input logic a0);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    case (bg)
      2'd1: for (int i = 0; i < int'(DATA_WIDTH); i++) p[i] = ~i[0];
      2'd2: p = {DATA_WIDTH{a0}};
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic is_down(input logic [EW-1:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic is_rw(input logic [EW-1:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [EW-1:0] e);
    return is_down(e) ? A_LAST : '0;
  endfunction

  function automatic logic first_lsb(input logic [EW-1:0] e);
    return is_down(e) ? A_LAST[0] : 1'b0;
  endfunction

  function automatic logic is_last(input logic [EW-1:0] e, input logic [ADDR_WIDTH-1:0] a);
    return is_down(e) ? (a == '0) : (a == A_LAST);
  endfunction

  // Value written by element e at an address with LSB a0 (0 beyond E4).
  function automatic logic [DATA_WIDTH-1:0] wval(input logic [1:0] bg, input logic [EW-1:0] e,
                                                 input logic a0);
    case (e)
      3'd0, 3'd2, 3'd4: return pat(bg, a0);
      3'd1, 3'd3:       return ~pat(bg, a0);
      default:          return '0;
    endcase
  endfunction

  // Value expected by the read of element e.
  function automatic logic [DATA_WIDTH-1:0] rexp(input logic [1:0] bg, input logic [EW-1:0] e,
                                                 input logic a0);
    case (e)
      3'd1, 3'd3, 3'd5: return pat(bg, a0);
      3'd2, 3'd4:       return ~pat(bg, a0);
      default:          return '0;
    endcase
  endfunction

  state_t                r_st, w_st_n;
  logic [EW-1:0]         r_elem, w_elem_n, w_elem_inc, w_nelem;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic                  r_ph, w_ph_n;
  logic                  r_drain, w_drain_n;
  logic                  w_accept;
  logic [1:0]            r_bg, w_bg;
  logic                  w_wr_n;
  logic [ADDR_WIDTH-1:0] w_address_n;
  logic [DATA_WIDTH-1:0] w_wdata_n;

  // Read-compare pipeline: stage 1 captures the read issued this cycle.
  logic                  r_p1_v, r_p2_v;
  logic [ADDR_WIDTH-1:0] r_p1_a, r_p2_a;
  logic [EW-1:0]         r_p1_e, r_p2_e;
  logic [DATA_WIDTH-1:0] r_p1_x, r_p2_x;

  // Next state and next registered bus outputs.
  always_comb begin
    w_st_n      = r_st;
    w_elem_n    = r_elem;
    w_addr_n    = r_addr;
    w_ph_n      = r_ph;
    w_drain_n   = r_drain;
    w_accept    = 1'b0;
    w_elem_inc  = r_elem + 3'd1;
    w_wr_n      = 1'b0;
    w_address_n = '0;
    w_wdata_n   = '0;

    case (r_st)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_st_n   = S_PREP;
          w_elem_n = '0;
          w_addr_n = '0;
          w_ph_n   = 1'b0;
        end
      end
      S_PREP: w_st_n = S_RUN;
      S_RUN: begin
        if (is_rw(r_elem) && !r_ph) begin
          w_ph_n = 1'b1;
        end else begin
          w_ph_n = 1'b0;
          if (is_last(r_elem, r_addr)) begin
            if (r_elem == 3'd5) begin
              w_st_n    = S_DRAIN;
              w_drain_n = 1'b0;
              w_addr_n  = '0;
            end else begin
              w_st_n   = S_PREP;
              w_elem_n = w_elem_inc;
              w_addr_n = first_addr(w_elem_inc);
            end
          end else begin
            w_addr_n = is_down(r_elem) ? r_addr - 1'b1 : r_addr + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain) w_st_n = S_DONE;
        else         w_drain_n = 1'b1;
      end
      default: w_st_n = S_IDLE;
    endcase

    w_bg    = w_accept ? bg_mode : r_bg;
    w_nelem = w_elem_n + 3'd1;

    // wdata always carries the value of the next write strictly after this cycle.
    if (w_st_n == S_PREP) begin
      w_address_n = w_addr_n;
      w_wdata_n   = wval(w_bg, w_elem_n, w_addr_n[0]);
    end else if (w_st_n == S_RUN) begin
      w_address_n = w_addr_n;
      w_wr_n      = (w_elem_n == 3'd0) || (is_rw(w_elem_n) && w_ph_n);
      if (is_rw(w_elem_n) && !w_ph_n)
        w_wdata_n = wval(w_bg, w_elem_n, w_addr_n[0]);
      else if (is_last(w_elem_n, w_addr_n))
        w_wdata_n = wval(w_bg, w_nelem, first_lsb(w_nelem));
      else
        w_wdata_n = wval(w_bg, w_elem_n, ~w_addr_n[0]);
    end
  end

  // State, bus outputs and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= S_IDLE;
      r_elem     <= '0;
      r_addr     <= '0;
      r_ph       <= 1'b0;
      r_drain    <= 1'b0;
      r_bg       <= '0;
      write_read <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_cnt   <= '0;
      r_p1_v     <= 1'b0;
      r_p1_a     <= '0;
      r_p1_e     <= '0;
      r_p1_x     <= '0;
      r_p2_v     <= 1'b0;
      r_p2_a     <= '0;
      r_p2_e     <= '0;
      r_p2_x     <= '0;
    end else begin
      r_st       <= w_st_n;
      r_elem     <= w_elem_n;
      r_addr     <= w_addr_n;
      r_ph       <= w_ph_n;
      r_drain    <= w_drain_n;
      r_bg       <= w_bg;
      write_read <= w_wr_n;
      address    <= w_address_n;
      wdata      <= w_wdata_n;
      busy       <= (w_st_n == S_PREP) || (w_st_n == S_RUN) || (w_st_n == S_DRAIN);
      done       <= (w_st_n == S_DONE);

      r_p1_v <= (r_st == S_RUN) && !write_read;
      r_p1_a <= address;
      r_p1_e <= r_elem;
      r_p1_x <= rexp(r_bg, r_elem, address[0]);
      r_p2_v <= r_p1_v;
      r_p2_a <= r_p1_a;
      r_p2_e <= r_p1_e;
      r_p2_x <= r_p1_x;

      if (w_accept) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_cnt  <= '0;
      end else if (r_p2_v && (rdata != r_p2_x)) begin
        fail <= 1'b1;
        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
        if (!fail) begin
          fail_addr <= r_p2_a;
          fail_elem <= r_p2_e;
        end
      end
    end
  end

endmodule
